// File: rtl/gamma_ctrl.sv
// Gamma-cycle controller: latches one set of spike times, replays them as pulses
// over a fixed RUN window, and reports the first cycle the datapath output went high.
module gamma_ctrl #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int N_IN              = 4,
    localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic               aclk,
    input  logic               grst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN*TW-1:0] in_time,
    output logic [N_IN-1:0]    spike_out,
    output logic               prim_rst,
    input  logic               net_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TW-1:0]      out_time,
    output logic               out_none
);

    localparam logic [TW-1:0] NO_SPIKE = TW'(GAMMA_CYCLE_WIDTH);
    localparam logic [TW-1:0] LAST_T   = TW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [TW:0]   PW       = (TW + 1)'(PULSE_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic            cap_q, cap_d;
    logic [TW-1:0]   out_time_q, out_time_d;
    logic            out_none_q, out_none_d;
    logic            prim_rst_q, prim_rst_d;
    logic            in_ready_q, in_ready_d;
    logic            accept;
    logic [TW-1:0]   time_q [N_IN];
    logic [TW-1:0]   time_d [N_IN];

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q    <= IDLE;
            t_q        <= '0;
            cap_q      <= 1'b0;
            out_time_q <= '0;
            out_none_q <= 1'b0;
            prim_rst_q <= 1'b1;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            cap_q      <= cap_d;
            out_time_q <= out_time_d;
            out_none_q <= out_none_d;
            prim_rst_q <= prim_rst_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        cap_d      = cap_q;
        out_time_d = out_time_q;
        out_none_d = out_none_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                t_d     = '0;
                cap_d   = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                t_d = t_q + 1'b1;
                if (net_y && !cap_q) begin
                    cap_d      = 1'b1;
                    out_time_d = t_q;
                end
                // A capture on the last RUN cycle still counts, so decide on cap_d.
                if (t_q == LAST_T) begin
                    state_d    = REPORT;
                    out_none_d = !cap_d;
                    if (!cap_d) begin
                        out_time_d = NO_SPIKE;
                    end
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        prim_rst_d = (state_d == CLEAR);
        in_ready_d = (state_d == IDLE);
    end

    // One lane per spike line: time latch plus pulse-window compare.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
        always_comb begin
            time_d[gi] = time_q[gi];
            if (accept) begin
                time_d[gi] = in_time[gi*TW +: TW];
            end
        end

        always_ff @(posedge aclk or negedge grst_n) begin
            if (!grst_n) begin
                time_q[gi] <= NO_SPIKE;
            end else begin
                time_q[gi] <= time_d[gi];
            end
        end

        assign spike_out[gi] = (state_q == RUN)
                             && (time_q[gi] < NO_SPIKE)
                             && (t_q >= time_q[gi])
                             && ({1'b0, t_q} < ({1'b0, time_q[gi]} + PW));
    end

    assign in_ready  = in_ready_q;
    assign prim_rst  = prim_rst_q;
    assign out_valid = (state_q == REPORT);
    assign out_time  = out_time_q;
    assign out_none  = out_none_q;

endmodule
